// File: rtl/univ_shift_reg_pkg.sv
// usr_pkg: mode and burst-controller state encodings shared by univ_shift_reg, its interface and usr_burst_ctrl
package usr_pkg;
  typedef enum logic [2:0] {
    USR_HOLD = 3'd0,
    USR_SHR  = 3'd1,
    USR_SHL  = 3'd2,
    USR_LOAD = 3'd3,
    USR_ROR  = 3'd4,
    USR_ROL  = 3'd5
  } usr_mode_e;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } usr_state_e;
endpackage

// File: rtl/univ_shift_reg_if.sv
// univ_shift_reg_if: shift-register bus; master drives mode/si/sil/pi/start/burst_len, slave drives so/sol/po/busy/done
interface univ_shift_reg_if #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [2:0]             mode;
  logic [WIDTH-1:0]       si;
  logic [WIDTH-1:0]       sil;
  logic [DEPTH*WIDTH-1:0] pi;
  logic                   start;
  logic [CW-1:0]          burst_len;
  logic [WIDTH-1:0]       so;
  logic [WIDTH-1:0]       sol;
  logic [DEPTH*WIDTH-1:0] po;
  logic                   busy;
  logic                   done;
  modport master (output mode, si, sil, pi, start, burst_len, input so, sol, po, busy, done);
  modport slave  (input mode, si, sil, pi, start, burst_len, output so, sol, po, busy, done);
endinterface

// File: rtl/univ_shift_reg_burst_ctrl.sv
// usr_burst_ctrl: burst FSM (clk, clear, start, burst_len in; busy, done, shift_en, mode_en out); burst_len saturates at DEPTH
module usr_burst_ctrl
  import usr_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          start,
  input  logic [CW-1:0] burst_len,
  output logic          busy,
  output logic          done,
  output logic          shift_en,
  output logic          mode_en
);
  usr_state_e    state, state_n;
  logic [CW-1:0] cnt, cnt_n, len_sat;
  assign len_sat = (burst_len > CW'(DEPTH)) ? CW'(DEPTH) : burst_len;
  assign busy = state == ST_BURST;
  assign done = state == ST_DONE;
  always_ff @(posedge clk or posedge clear)
    if (clear) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    shift_en = 1'b0;
    mode_en  = 1'b0;
    case (state)
      ST_IDLE: begin
        mode_en = !start;
        if (start) begin
          cnt_n   = len_sat;
          state_n = (len_sat == '0) ? ST_DONE : ST_BURST;
        end
      end
      ST_BURST: begin
        shift_en = 1'b1;
        cnt_n    = cnt - 1'b1;
        state_n  = (cnt == CW'(1)) ? ST_DONE : ST_BURST;
      end
      default: state_n = ST_IDLE;
    endcase
  end
endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: DEPTH x WIDTH multi-mode shift register (clk, clear, bus: mode/si/sil/pi/start/burst_len in, so/sol/po/busy/done out); USR_ROTATE_EN enables ROR/ROL
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8
) (
  input logic              clk,
  input logic              clear,
  univ_shift_reg_if.slave  bus
);
  logic [DEPTH-1:0][WIDTH-1:0] stg, nxt;
  logic shift_en, mode_en;
  usr_burst_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clk       (clk),
    .clear     (clear),
    .start     (bus.start),
    .burst_len (bus.burst_len),
    .busy      (bus.busy),
    .done      (bus.done),
    .shift_en  (shift_en),
    .mode_en   (mode_en)
  );
  assign bus.po  = stg;
  assign bus.so  = stg[DEPTH-1];
  assign bus.sol = stg[0];
  always_comb begin
    nxt = stg;
    if (shift_en) nxt = {stg[DEPTH-2:0], bus.si};
    else if (mode_en)
      case (bus.mode)
        USR_SHR:  nxt = {stg[DEPTH-2:0], bus.si};
        USR_SHL:  nxt = {bus.sil, stg[DEPTH-1:1]};
        USR_LOAD: nxt = bus.pi;
`ifdef USR_ROTATE_EN
        USR_ROR:  nxt = {stg[DEPTH-2:0], stg[DEPTH-1]};
        USR_ROL:  nxt = {stg[0], stg[DEPTH-1:1]};
`endif
        default:  nxt = stg;
      endcase
  end
  always_ff @(posedge clk or posedge clear)
    if (clear) stg <= '0;
    else stg <= nxt;
endmodule
